// File: rtl/rl_pkg.sv
// Shared types and constants for the 4-action Q-learning agent datapath.
// Q-values are signed Q8.8; actions are carried one-hot.
package rl_pkg;

    localparam int NUM_ACTIONS = 4;
    localparam int Q_WIDTH     = 16;
    localparam int Q_FRAC      = 8;

    typedef logic signed [Q_WIDTH-1:0] q_value_t;
    typedef logic [NUM_ACTIONS-1:0]    action_onehot_t;

    // 0x00CD in unsigned Q8.8 is roughly 0.80
    localparam logic [15:0] EPS_THRESHOLD_DEFAULT = 16'h00CD;
    localparam logic [15:0] LFSR_SEED_DEFAULT     = 16'hACE1;

endpackage

// File: rtl/action_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
// SEED is the reset state and must be non-zero.
module action_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy one-hot action selector with a single registered output stage.
// The LFSR exploration path is built only when ACTION_SELECTOR_EXPLORE_EN is defined; otherwise pure greedy.
module action_selector
    import rl_pkg::*;
#(
    parameter logic [15:0] EPS_THRESHOLD = EPS_THRESHOLD_DEFAULT,
    parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
    input  logic [15:0]                    epsilon,
    output action_onehot_t                 action,
    output logic                           out_valid,
    output logic                           explored
);

    // Two-level tournament; strict greater-than keeps the lower index on ties.
    function automatic action_onehot_t argmax_onehot(input logic [NUM_ACTIONS*Q_WIDTH-1:0] qv);
        q_value_t   q0, q1, q2, q3;
        q_value_t   m01, m23;
        logic [1:0] w01, w23, w;
        q0  = qv[15:0];
        q1  = qv[31:16];
        q2  = qv[47:32];
        q3  = qv[63:48];
        w01 = (q1 > q0) ? 2'd1 : 2'd0;
        m01 = (q1 > q0) ? q1 : q0;
        w23 = (q3 > q2) ? 2'd3 : 2'd2;
        m23 = (q3 > q2) ? q3 : q2;
        w   = (m23 > m01) ? w23 : w01;
        return 4'b0001 << w;
    endfunction

    action_onehot_t greedy_p0;
    action_onehot_t action_sel_p0;
    logic           explore_p0;

    assign greedy_p0 = argmax_onehot(q_values);

`ifdef ACTION_SELECTOR_EXPLORE_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    action_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Explore uses the LFSR state seen before the capturing edge.
    assign explore_p0    = (epsilon < EPS_THRESHOLD);
    assign action_sel_p0 = explore_p0 ? action_onehot_t'(4'b0001 << lfsr_state[1:0]) : greedy_p0;
    assign unused_lfsr   = ^lfsr_state[15:2];
`else
    logic unused_cfg;

    assign explore_p0    = 1'b0;
    assign action_sel_p0 = greedy_p0;
    assign unused_cfg    = ^{epsilon, EPS_THRESHOLD, LFSR_SEED};
`endif

    // ---- stage p1: registered result; action/explored hold while idle ----
    action_onehot_t action_p1;
    logic           explored_p1;
    logic           vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            action_p1   <= '0;
            explored_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                action_p1   <= action_sel_p0;
                explored_p1 <= explore_p0;
            end
        end
    end

    assign action    = action_p1;
    assign explored  = explored_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: vector table plus scoreboard queue, random greedy sweep and mid-stream reset.
// Follows whichever build of ACTION_SELECTOR_EXPLORE_EN the design is compiled with.
module tb_action_selector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] q_values = '0;
    logic [15:0] epsilon = '0;
    logic [3:0]  action;
    logic        out_valid;
    logic        explored;

    always #5 clk = ~clk;

    action_selector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .q_values  (q_values),
        .epsilon   (epsilon),
        .action    (action),
        .out_valid (out_valid),
        .explored  (explored)
    );

    typedef struct {
        logic [63:0] q;
        logic [15:0] eps;
        logic [3:0]  greedy;
    } vec_t;

    typedef struct {
        logic [3:0] act;
        logic       expl;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] last_act  = 4'b0000;
    logic       last_expl = 1'b0;

`ifdef ACTION_SELECTOR_EXPLORE_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif

    function automatic exp_t model(input logic [15:0] eps, input logic [3:0] greedy);
        exp_t e;
        e.act  = greedy;
        e.expl = 1'b0;
`ifdef ACTION_SELECTOR_EXPLORE_EN
        if (eps < 16'h00CD) begin
            e.act  = 4'b0001 << m_lfsr[1:0];
            e.expl = 1'b1;
        end
`else
        if (eps == 16'hDEAD) e.expl = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [3:0] ref_argmax(input logic [63:0] q);
        int best = 0;
        for (int i = 1; i < 4; i++) begin
            if ($signed(q[i*16 +: 16]) > $signed(q[best*16 +: 16])) best = i;
        end
        return 4'b0001 << best;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] q, input logic [15:0] e,
                        input logic [3:0] greedy, input string tag);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        q_values = q;
        epsilon  = e;
        if (v) sb.push_back(model(e, greedy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                check({tag, ".action"}, 32'(action), 32'(x.act));
                check({tag, ".explored"}, 32'(explored), 32'(x.expl));
                last_act  = x.act;
                last_expl = x.expl;
            end
        end else begin
            check({tag, ".hold_action"}, 32'(action), 32'(last_act));
            check({tag, ".hold_explored"}, 32'(explored), 32'(last_expl));
        end
    endtask

    initial begin
        logic [63:0] rq;
        logic [15:0] re;

        vecs[0] = '{64'h000C_0001_0002_0003, 16'h00E0, 4'b1000};
        vecs[1] = '{64'h000C_0001_0002_0007, 16'h00C0, 4'b1000};
        vecs[2] = '{64'h0010_0010_0010_0010, 16'h0100, 4'b0001};
        vecs[3] = '{64'hFF00_FE00_FE00_FE00, 16'h0100, 4'b1000};
        vecs[4] = '{64'h0001_0002_0050_0003, 16'h00CD, 4'b0010};
        vecs[5] = '{64'h0001_0002_0050_0003, 16'h00CC, 4'b0010};
        vecs[6] = '{64'h0000_7FFF_8000_0000, 16'hFFFF, 4'b0100};
        vecs[7] = '{64'h0000_0000_0000_0000, 16'h0000, 4'b0001};
        vecs[8] = '{64'hFFFE_8001_8000_FFFF, 16'h0100, 4'b0001};
        vecs[9] = '{64'h0040_0040_0010_0020, 16'h0100, 4'b0100};

        #1;
        check("reset.action", 32'(action), 32'h0);
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.explored", 32'(explored), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 64'h0, 16'h0, 4'b0000, "idle0");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].q, vecs[i].eps, vecs[i].greedy, $sformatf("vec%0d", i));
        end
        step(1'b0, 64'h0, 16'h0, 4'b0000, "idle1");
        step(1'b0, 64'h0, 16'h0, 4'b0000, "idle2");

        for (int i = 0; i < 24; i++) begin
            rq = {$urandom(), $urandom()};
            re = 16'($urandom_range(0, 16'h01FF));
            step(1'b1, rq, re, ref_argmax(rq), $sformatf("rnd%0d", i));
        end

        // Reset mid-cycle with a valid input pending: outputs must clear at once.
        @(negedge clk);
        in_valid = 1'b1;
        q_values = 64'h0100_0000_0000_0000;
        epsilon  = 16'h0100;
        #2 rst = 1'b1;
        #1;
        check("midrst.action", 32'(action), 32'h0);
        check("midrst.out_valid", 32'(out_valid), 32'h0);
        check("midrst.explored", 32'(explored), 32'h0);
        @(posedge clk);
        #1;
        check("midrst.held_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        last_act  = 4'b0000;
        last_expl = 1'b0;
        step(1'b0, 64'h0, 16'h0, 4'b0000, "postrst_idle");
        step(1'b1, vecs[1].q, vecs[1].eps, vecs[1].greedy, "postrst_explore");
        step(1'b1, vecs[5].q, vecs[5].eps, vecs[5].greedy, "postrst_below");
        step(1'b1, vecs[7].q, vecs[7].eps, vecs[7].greedy, "postrst_zero");
        step(1'b1, vecs[4].q, vecs[4].eps, vecs[4].greedy, "postrst_thresh");
        step(1'b0, 64'h0, 16'h0, 4'b0000, "final_idle");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
